// File: rtl/pe_array_drain_pkg.sv
// Shared constants and FSM state type for the PE array result drain.
package pe_array_drain_pkg;

    localparam int unsigned PE_N         = 8;
    localparam int unsigned PE_ROWS      = 4;
    localparam int unsigned PE_COLS      = 4;
    localparam int unsigned PE_SHIFT_LAT = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } drain_state_e;

endpackage

// File: rtl/pe_array_drain_rowbuf.sv
// COLS x N capture buffer; one slot written per cycle, packed with column 0 in the low bits.
module pe_drain_rowbuf
    import pe_array_drain_pkg::*;
#(
    parameter int unsigned N      = PE_N,
    parameter int unsigned COLS   = PE_COLS,
    localparam int unsigned SLOT_W = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              wr_en_i,
    input  logic [SLOT_W-1:0] wr_slot_i,
    input  logic [N-1:0]      wr_data_i,
    output logic [COLS*N-1:0] data_o
);

    logic [N-1:0] buf_q [COLS];

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int unsigned i = 0; i < COLS; i++) begin
                buf_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            buf_q[wr_slot_i] <= wr_data_i;
        end
    end

    always_comb begin
        data_o = '0;
        for (int unsigned i = 0; i < COLS; i++) begin
            data_o[i*N +: N] = buf_q[i];
        end
    end

endmodule

// File: rtl/pe_array_drain.sv
// Drain controller for the systolic PE array: shifts each row out of column 3,
// reorders the elements into column order and hands the row downstream on valid/ready.
module pe_array_drain
    import pe_array_drain_pkg::*;
#(
    parameter int unsigned N         = PE_N,
    parameter int unsigned ROWS      = PE_ROWS,
    parameter int unsigned COLS      = PE_COLS,
    parameter int unsigned SHIFT_LAT = PE_SHIFT_LAT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [1:0]        row_out,
    output logic              OutputSign,
    input  logic [N-1:0]      output_row,
    output logic [COLS*N-1:0] res_data,
    output logic [1:0]        res_row,
    output logic              res_valid,
    input  logic              res_ready
);

    localparam int unsigned CNT_W  = $clog2(SHIFT_LAT + COLS + 1);
    localparam int unsigned SLOT_W = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [CNT_W-1:0] CNT_OS_END    = CNT_W'(COLS);
    localparam logic [CNT_W-1:0] CNT_CAP_FIRST = CNT_W'(SHIFT_LAT);
    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(SHIFT_LAT + COLS - 1);
    localparam logic [1:0]       LAST_ROW      = 2'(ROWS - 1);

    drain_state_e      state_q, state_d;
    logic [1:0]        row_q, row_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              wr_en;
    logic [SLOT_W-1:0] wr_slot;
    logic [COLS*N-1:0] buf_data;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            row_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        cnt_d      = cnt_q;
        busy       = 1'b0;
        done       = 1'b0;
        row_out    = '0;
        OutputSign = 1'b0;
        res_valid  = 1'b0;
        wr_en      = 1'b0;
        // Column 3 arrives first, so slot index counts down from the last capture cycle.
        wr_slot    = SLOT_W'(CNT_LAST - cnt_q);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    row_d   = '0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                busy       = 1'b1;
                row_out    = row_q;
                OutputSign = (cnt_q < CNT_OS_END);
                wr_en      = (cnt_q >= CNT_CAP_FIRST);
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                busy      = 1'b1;
                row_out   = row_q;
                res_valid = 1'b1;
                if (res_ready) begin
                    if (row_q == LAST_ROW) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                        row_d   = row_q + 1'b1;
                        cnt_d   = '0;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    pe_drain_rowbuf #(
        .N    (N),
        .COLS (COLS)
    ) u_rowbuf (
        .clk_i     (clk),
        .rstn_i    (rstn),
        .wr_en_i   (wr_en),
        .wr_slot_i (wr_slot),
        .wr_data_i (output_row),
        .data_o    (buf_data)
    );

    // Buffer is not written in HOLD, so gating by valid keeps data stable under backpressure.
    assign res_data = res_valid ? buf_data : '0;
    assign res_row  = res_valid ? row_q : '0;

endmodule

// File: tb/tb_pe_array_drain.sv
// Bench for pe_array_drain: array stream models feed two instances (SHIFT_LAT 1 and 2).
module tb_pe_array_drain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn, start, ready1;
    logic ready2 = 1'b1;

    logic        busy1, done1, os1, valid1;
    logic [1:0]  row1, rrow1;
    logic [7:0]  orow1;
    logic [31:0] data1;

    logic        busy2, done2, os2, valid2;
    logic [1:0]  row2, rrow2;
    logic [7:0]  orow2, stage2;
    logic [31:0] data2;

    pe_array_drain u_dut1 (
        .clk(clk), .rstn(rstn), .start(start), .busy(busy1), .done(done1),
        .row_out(row1), .OutputSign(os1), .output_row(orow1),
        .res_data(data1), .res_row(rrow1), .res_valid(valid1), .res_ready(ready1)
    );

    pe_array_drain #(.SHIFT_LAT(2)) u_dut2 (
        .clk(clk), .rstn(rstn), .start(start), .busy(busy2), .done(done2),
        .row_out(row2), .OutputSign(os2), .output_row(orow2),
        .res_data(data2), .res_row(rrow2), .res_valid(valid2), .res_ready(ready2)
    );

    // Array contents: row r, column c lives at byte r*4+c.
    logic [127:0] mem = '0;
    int idx1 = 0;
    int idx2 = 0;

    function automatic logic [7:0] elem(input logic [1:0] r, input int k);
        int col;
        col = 3 - k;
        return mem[(int'(r) * 4 + col) * 8 +: 8];
    endfunction

    // Each OutputSign edge shifts the next element (column 3 first) out after the given latency.
    always @(posedge clk) begin
        if (!rstn) begin
            idx1  <= 0;
            orow1 <= '0;
        end else if (os1) begin
            orow1 <= elem(row1, idx1);
            idx1  <= (idx1 + 1) % 4;
        end else begin
            orow1 <= 8'($urandom);
        end
    end

    always @(posedge clk) begin
        if (!rstn) begin
            idx2   <= 0;
            stage2 <= '0;
            orow2  <= '0;
        end else begin
            if (os2) begin
                stage2 <= elem(row2, idx2);
                idx2   <= (idx2 + 1) % 4;
            end else begin
                stage2 <= 8'($urandom);
            end
            orow2 <= stage2;
        end
    end

    typedef struct {
        logic [1:0]  row;
        logic [31:0] data;
    } xfer_t;

    xfer_t q1[$];
    xfer_t q2[$];
    int done_cnt1 = 0;
    int done_cnt2 = 0;
    int os_row1 [4] = '{0, 0, 0, 0};
    int os_row2 [4] = '{0, 0, 0, 0};

    always @(negedge clk) begin
        if (valid1 && ready1) q1.push_back('{rrow1, data1});
        if (valid2 && ready2) q2.push_back('{rrow2, data2});
        if (done1) done_cnt1++;
        if (done2) done_cnt2++;
        if (os1) os_row1[row1]++;
        if (os2) os_row2[row2]++;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // mode 0: ready tied 1; mode 1: random ready; mode 2: ready low until cycle 13.
    task automatic run_drain(input string tag, input logic [127:0] contents, input int mode,
                             input int pulse_n, input bit pulse_done, input logic [31:0] exp_row1);
        int s1, s2, d1, d2, lat, first1, first2;
        int o1 [4];
        int o2 [4];
        mem = contents;
        s1 = q1.size();
        s2 = q2.size();
        d1 = done_cnt1;
        d2 = done_cnt2;
        o1 = os_row1;
        o2 = os_row2;
        lat = -1;
        first1 = -1;
        first2 = -1;
        @(posedge clk); #1;
        start  = 1'b1;
        ready1 = (mode == 0);
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk); #1;
            start = (n == pulse_n);
            case (mode)
                0:       ready1 = 1'b1;
                1:       ready1 = 1'($urandom_range(0, 1));
                default: ready1 = (n >= 13);
            endcase
            if (valid1 && first1 < 0) first1 = n;
            if (valid2 && first2 < 0) first2 = n;
            if (mode == 2 && n >= 6 && n <= 13) begin
                chk({tag, " bp_data"}, data1, contents[31:0]);
                chk({tag, " bp_valid_os"}, {30'd0, valid1, os1}, 32'd2);
            end
            if (mode == 2 && n == 14) chk({tag, " bp_row1_shift"}, {29'd0, row1, os1}, 32'd3);
            if (done1) begin
                lat = n;
                break;
            end
        end
        if (pulse_done && lat > 0) begin
            start = 1'b1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk({tag, " done_timeout"}, 32'(lat > 0), 32'd1);
        chk({tag, " done_count"}, 32'(done_cnt1 - d1), 32'd1);
        chk({tag, " result_count"}, 32'(q1.size() - s1), 32'd4);
        chk({tag, " idle_after"}, {30'd0, busy1, valid1}, 32'd0);
        if (q1.size() - s1 >= 4) begin
            for (int r = 0; r < 4; r++) begin
                chk({tag, " row_idx"}, 32'(q1[s1 + r].row), 32'(r));
                chk({tag, " row_data"}, q1[s1 + r].data, contents[r*32 +: 32]);
                chk({tag, " os_cycles"}, 32'(os_row1[r] - o1[r]), 32'd4);
            end
            chk({tag, " row1_const"}, q1[s1 + 1].data, exp_row1);
        end
        if (mode == 0) begin
            chk({tag, " done_latency"}, 32'(lat), 32'd25);
            chk({tag, " first_valid"}, 32'(first1), 32'd6);
        end
        if (mode == 2) chk({tag, " bp_done_latency"}, 32'(lat), 32'd32);
        chk({tag, " lat2_first_valid"}, 32'(first2), 32'd7);
        chk({tag, " lat2_done_count"}, 32'(done_cnt2 - d2), 32'd1);
        chk({tag, " lat2_result_count"}, 32'(q2.size() - s2), 32'd4);
        if (q2.size() - s2 >= 4) begin
            for (int r = 0; r < 4; r++) begin
                chk({tag, " lat2_row_data"}, q2[s2 + r].data, contents[r*32 +: 32]);
                chk({tag, " lat2_os_cycles"}, 32'(os_row2[r] - o2[r]), 32'd4);
            end
        end
    endtask

    typedef struct {
        string        name;
        logic [127:0] contents;
        int           mode;
        int           pulse_n;
        bit           pulse_done;
        logic [31:0]  exp_row1;
    } vec_t;

    vec_t tbl [5];

    initial begin
        tbl[0] = '{"incr", 128'h33323130_23222120_13121110_03020100, 0, 0, 1'b0, 32'h13121110};
        tbl[1] = '{"ignored_start", 128'h33323130_23222120_13121110_03020100, 0, 8, 1'b1, 32'h13121110};
        tbl[2] = '{"extremes", 128'h00FF00FF_FF00FF00_00FF00FF_FF00FF00, 0, 0, 1'b0, 32'h00FF00FF};
        tbl[3] = '{"extremes_inv", 128'hFF00FF00_00FF00FF_FF00FF00_00FF00FF, 0, 0, 1'b0, 32'hFF00FF00};
        tbl[4] = '{"backpressure", 128'h33323130_23222120_13121110_03020100, 2, 0, 1'b0, 32'h13121110};

        rstn   = 1'b0;
        start  = 1'b0;
        ready1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", {26'd0, busy1, done1, os1, valid1, row1}, 32'd0);
        chk("reset_data", data1 | {30'd0, rrow1}, 32'd0);
        rstn = 1'b1;

        // Abort in the middle of row 2's shift phase.
        mem = 128'h33323130_23222120_13121110_03020100;
        @(posedge clk); #1;
        start  = 1'b1;
        ready1 = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("pre_reset_row2_shift", {29'd0, row1, os1}, 32'd5);
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("mid_reset_ctrl", {26'd0, busy1, done1, os1, valid1, row1}, 32'd0);
        chk("mid_reset_data", data1, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_reset_stays_idle", {30'd0, busy1, os1}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_drain(tbl[i].name, tbl[i].contents, tbl[i].mode, tbl[i].pulse_n,
                      tbl[i].pulse_done, tbl[i].exp_row1);
        end

        for (int i = 0; i < 6; i++) begin
            logic [127:0] c;
            c = {$urandom(), $urandom(), $urandom(), $urandom()};
            run_drain("random", c, 1, 0, 1'b0, c[63:32]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
